b2d_seq_converter: RTL and testbench
====================================

# b2d_seq_converter

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one iteration per clock. It takes a WIDTH-bit unsigned or two's-complement value over a valid/ready handshake and returns DIGITS packed BCD digits. It also returns sign, overflow and leading-zero blanking flags. It sits between datapath counters/ALU results and the 7-segment display drivers, and replaces wide combinational conversion where timing or area is tight.

## Interface
- WIDTH, 16, binary input width; legal range ≥2.
- DIGITS, 5, BCD output digit count; legal range ≥1. Values too small to hold 2^WIDTH−1 are legal; overflow is flagged.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  converter idle; high only in IDLE.
- in_bin  input  WIDTH  binary operand; sampled on handshake only.
- in_signed  input  1  1 = treat in_bin as two's complement; sampled on handshake.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_bcd  output  DIGITS*4  packed BCD; digit j is bits [4j+3:4j], with digit 0 least significant.
- out_neg  output  1  result is negative.
- out_ovf  output  1  magnitude ≥ 10^DIGITS; out_bcd holds magnitude mod 10^DIGITS.
- out_blank  output  DIGITS  bit j set when digit j is a leading zero; bit 0 is always 0.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch operands, go to SHIFT.
  - SHIFT: performs WIDTH iterations, counted by a ⌈log2(WIDTH+1)⌉-bit counter. Goes to DONE after the last iteration.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Operand latch:
  - If in_signed=1 and in_bin[WIDTH−1]=1, load magnitude = (~in_bin + 1) as WIDTH bits unsigned, and set neg=1.
  - Otherwise load in_bin unchanged, with neg=0.
  - The most negative value −2^(WIDTH−1) yields magnitude 2^(WIDTH−1); this is legal.
- One iteration, implemented in sub-module:
  - For every digit j: if digit ≥ 5, add 3 (4-bit result).
  - Then shift the {digits, binary} register left 1.
- Overflow: the bit shifted out of the top digit is OR-accumulated into a sticky ovf. The ovf accumulator clears at accept.
- On the SHIFT→DONE transition, register the following together, in the same edge:
  - out_bcd
  - out_neg
  - out_ovf
  - out_blank, where bit j = 1 when j>0 and digits j..DIGITS−1 are all zero.
- Zero input gives out_neg=0 even in signed mode.
- Result outputs hold their value after DONE→IDLE until the next SHIFT→DONE transition. They are stable for the whole time out_valid is high, regardless of out_ready.
- in_bin and in_signed changes after acceptance have no effect.

## Timing
- Reset values:
  - State = IDLE, so in_ready=1 and out_valid=0.
  - out_bcd=0, out_neg=0, out_ovf=0, out_blank=0.
  - Iteration counter = 0.
- Assertion of rst mid-conversion or in DONE aborts the conversion immediately. The result is discarded and no out_valid is issued.
- Latency: with handshake at edge E0, out_valid rises after edge E0+WIDTH, i.e. it is high during cycle WIDTH+1.
- DONE with out_ready=1 returns to IDLE at the next edge. in_ready is low in DONE, so no same-cycle turnaround.
- Minimum period per conversion: WIDTH+2 cycles.
- out_ready held low stalls DONE indefinitely, and outputs hold.
- in_ready and out_valid are decoded from the state register only; there is no combinational path from in_valid or out_ready.

## Structure
- Shared package b2d_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - BCD_W=4
  - DABBLE_THRESH=5
  - DABBLE_ADJ=3
- Sub-module b2d_dabble_step:
  - Purely combinational, parametrised by WIDTH and DIGITS.
  - Takes {digits, binary}.
  - Returns the next {digits, binary} and the carry-out bit.
- The top level holds the FSM, counter, operand/sign latch, ovf accumulator and output registers.

## Test plan
- WIDTH=16, DIGITS=5, unsigned 65535:
  - out_valid high at cycle 17 after handshake.
  - out_bcd=0x65535, out_neg=0, out_ovf=0, out_blank=00000.
- Signed −1 (0xFFFF):
  - out_bcd=0x00001, out_neg=1, out_blank=11110.
- Signed 0x8000:
  - out_bcd=0x32768, out_neg=1.
- Unsigned 0:
  - out_bcd=0x00000, out_neg=0, out_blank=11110.
- Unsigned 42 with out_ready held low 10 cycles:
  - out_bcd=0x00042, out_blank=11100.
  - out_valid and outputs held for 10 cycles; in_ready low throughout.
  - in_ready returns 1 cycle after out_ready.
- WIDTH=12, DIGITS=3, input 1234:
  - out_bcd=0x234, out_ovf=1.
- Same configuration, rst pulse at iteration 5:
  - Returns to IDLE, no out_valid.
  - All outputs read 0.
  - Next conversion of 999 gives 0x999, out_ovf=0.

Source files
------------

// File: rtl/b2d_pkg.sv
// b2d_pkg: shared FSM states and double-dabble constants for the BCD converter
package b2d_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_W = 4;
  localparam int DABBLE_THRESH = 5;
  localparam int DABBLE_ADJ = 3;
endpackage

// File: rtl/b2d_dabble_step.sv
// b2d_dabble_step: one combinational shift-and-add-3 iteration over {digits, binary}; cur_i in, nxt_o shifted result, carry_o bit leaving the top digit
module b2d_dabble_step
  import b2d_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic [DIGITS*BCD_W+WIDTH-1:0] cur_i,
  output logic [DIGITS*BCD_W+WIDTH-1:0] nxt_o,
  output logic                          carry_o
);
  logic [DIGITS*BCD_W+WIDTH-1:0] adj;
  always_comb begin
    adj = cur_i;
    for (int j = 0; j < DIGITS; j++)
      adj[WIDTH+j*BCD_W +: BCD_W] = cur_i[WIDTH+j*BCD_W +: BCD_W] >= BCD_W'(DABBLE_THRESH) ?
                                    cur_i[WIDTH+j*BCD_W +: BCD_W] + BCD_W'(DABBLE_ADJ) :
                                    cur_i[WIDTH+j*BCD_W +: BCD_W];
  end
  assign nxt_o   = {adj[DIGITS*BCD_W+WIDTH-2:0], 1'b0};
  assign carry_o = adj[DIGITS*BCD_W+WIDTH-1];
endmodule

// File: rtl/b2d_seq_converter.sv
// b2d_seq_converter: sequential binary-to-BCD converter; in_valid/in_ready/in_bin/in_signed operand handshake, out_valid/out_ready result handshake with out_bcd, out_neg, out_ovf, out_blank
module b2d_seq_converter
  import b2d_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_bin,
  input  logic                      in_signed,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGITS*BCD_W-1:0]   out_bcd,
  output logic                      out_neg,
  output logic                      out_ovf,
  output logic [DIGITS-1:0]         out_blank
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int RW = DIGITS*BCD_W+WIDTH;
  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [RW-1:0]             sr_q, sr_d;
  logic                      neg_q, ovf_q, carry_d, neg_d;
  logic [WIDTH-1:0]          mag_d;
  logic [DIGITS*BCD_W-1:0]   bcd_d, out_bcd_q;
  logic [DIGITS-1:0]         blank_d, out_blank_q;
  logic                      out_neg_q, out_ovf_q;
  b2d_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
    .cur_i  (sr_q),
    .nxt_o  (sr_d),
    .carry_o(carry_d)
  );
  assign neg_d = in_signed & in_bin[WIDTH-1];
  assign mag_d = neg_d ? ~in_bin + 1'b1 : in_bin;
  assign bcd_d = sr_d[RW-1:WIDTH];
  // a digit is blank when it and every more significant digit are zero
  always_comb begin
    blank_d = '0;
    for (int j = 1; j < DIGITS; j++)
      blank_d[j] = (bcd_d >> (j*BCD_W)) == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_bcd_q   <= '0;
      out_neg_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_blank_q <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          sr_q    <= {{DIGITS*BCD_W{1'b0}}, mag_d};
          neg_q   <= neg_d;
          ovf_q   <= 1'b0;
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          ovf_q <= ovf_q | carry_d;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q     <= DONE;
            out_bcd_q   <= bcd_d;
            out_neg_q   <= neg_q;
            out_ovf_q   <= ovf_q | carry_d;
            out_blank_q <= blank_d;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_bcd   = out_bcd_q;
  assign out_neg   = out_neg_q;
  assign out_ovf   = out_ovf_q;
  assign out_blank = out_blank_q;
endmodule

// File: tb/tb_b2d_seq_converter.sv
// tb_b2d_seq_converter: table, corner-sequence and randomized checks of 16/5 and 12/3 converter instances
module tb_b2d_seq_converter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  iv, sg, ordy, ir, ov, ng, of;
  logic [15:0] bin16;
  logic [11:0] bin12;
  logic [19:0] bcd16;
  logic [11:0] bcd12;
  logic [4:0]  bl16;
  logic [2:0]  bl12;
  int          n_chk = 0, n_pass = 0;
  longint      r_bcd, r_blank, m_bcd, m_blank;
  bit          r_neg, r_ovf, m_neg, m_ovf;
  int          lat, vcnt;
  always #5 clk = ~clk;

  b2d_seq_converter #(.WIDTH(16), .DIGITS(5)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_bin(bin16), .in_signed(sg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_bcd(bcd16), .out_neg(ng[0]), .out_ovf(of[0]), .out_blank(bl16));
  b2d_seq_converter #(.WIDTH(12), .DIGITS(3)) u12 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_bin(bin12), .in_signed(sg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_bcd(bcd12), .out_neg(ng[1]), .out_ovf(of[1]), .out_blank(bl12));

  typedef struct {
    int     s;
    longint v;
    bit     sgn;
    int     stall;
    longint bcd;
    bit     neg;
    bit     ovf;
    longint blank;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic longint rd_bcd(input int s);
    return s != 0 ? longint'(bcd12) : longint'(bcd16);
  endfunction

  function automatic longint rd_blank(input int s);
    return s != 0 ? longint'(bl12) : longint'(bl16);
  endfunction

  // reference: magnitude by arithmetic, digits by repeated division
  function automatic void model(input int w, input int d, input longint v, input bit s,
                                output longint bcd, output bit neg, output bit ovf, output longint blank);
    longint mag, p10, m, p;
    neg = s && (((v >> (w-1)) & 1) == 1);
    mag = neg ? (longint'(1) << w) - v : v;
    p10 = 1;
    for (int i = 0; i < d; i++) p10 *= 10;
    ovf = mag >= p10;
    m = mag % p10;
    bcd = 0;
    blank = 0;
    p = 10;
    for (int j = 1; j < d; j++) begin
      if (m < p) blank |= longint'(1) << j;
      p *= 10;
    end
    for (int i = 0; i < d; i++) begin
      bcd |= (m % 10) << (4*i);
      m /= 10;
    end
  endfunction

  task automatic conv(input int s, input longint v, input bit sgn, input int stall,
                      output longint bcd, output bit neg, output bit ovf, output longint blank, output int l);
    int t = 0;
    @(negedge clk);
    while (!ir[s] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_idle", longint'(ir[s]), 1);
    if (s != 0) bin12 = v[11:0]; else bin16 = v[15:0];
    sg[s] = sgn;
    iv[s] = 1'b1;
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    bin16 = 16'($urandom);
    bin12 = 12'($urandom);
    sg = 2'($urandom);
    l = 0;
    while (l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (l == 1) chk("in_ready_busy", longint'(ir[s]), 0);
      if (ov[s]) break;
    end
    bcd = rd_bcd(s);
    blank = rd_blank(s);
    neg = ng[s];
    ovf = of[s];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_hold", longint'({ov[s], ir[s], rd_bcd(s) == bcd, rd_blank(s) == blank, ng[s] == neg, of[s] == ovf}), 6'b101111);
    end
    ordy[s] = 1'b1;
    @(posedge clk);
    #1;
    ordy[s] = 1'b0;
    @(negedge clk);
    chk("accept_idle", longint'({ov[s], ir[s]}), 2'b01);
    chk("hold_after_accept", rd_bcd(s), bcd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    iv = '0; sg = '0; ordy = '0; bin16 = '0; bin12 = '0;
    tv = '{
      '{0, 'hFFFF, 0, 0,  'h65535, 0, 0, 'b00000},
      '{0, 'hFFFF, 1, 0,  'h00001, 1, 0, 'b11110},
      '{0, 'h8000, 1, 0,  'h32768, 1, 0, 'b00000},
      '{0, 0,      0, 0,  0,       0, 0, 'b11110},
      '{0, 0,      1, 0,  0,       0, 0, 'b11110},
      '{0, 'h7FFF, 1, 0,  'h32767, 0, 0, 'b00000},
      '{0, 42,     0, 10, 'h00042, 0, 0, 'b11100},
      '{0, 10,     0, 0,  'h00010, 0, 0, 'b11100},
      '{1, 1234,   0, 0,  'h234,   0, 1, 'b000},
      '{1, 'hFFF,  1, 0,  'h001,   1, 0, 'b110},
      '{1, 'h800,  1, 0,  'h048,   1, 1, 'b100},
      '{1, 999,    0, 0,  'h999,   0, 0, 'b000},
      '{1, 1000,   0, 0,  'h000,   0, 1, 'b110}
    };
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_handshake", longint'({ov, ir}), 4'b0011);
    chk("reset_bcd16", longint'(bcd16), 0);
    chk("reset_flags16", longint'({ng[0], of[0], bl16}), 0);
    chk("reset_bcd12", longint'(bcd12), 0);
    rst = 1'b0;
    for (int i = 0; i < $size(tv); i++) begin
      conv(tv[i].s, tv[i].v, tv[i].sgn, tv[i].stall, r_bcd, r_neg, r_ovf, r_blank, lat);
      chk($sformatf("vec%0d_latency", i), lat, tv[i].s != 0 ? 12 : 16);
      chk($sformatf("vec%0d_bcd", i), r_bcd, tv[i].bcd);
      chk($sformatf("vec%0d_neg", i), longint'(r_neg), longint'(tv[i].neg));
      chk($sformatf("vec%0d_ovf", i), longint'(r_ovf), longint'(tv[i].ovf));
      chk($sformatf("vec%0d_blank", i), r_blank, tv[i].blank);
    end
    @(negedge clk);
    bin12 = 12'd3210;
    sg[1] = 1'b0;
    iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_state", longint'({ov[1], ir[1]}), 2'b01);
    chk("abort_bcd", longint'(bcd12), 0);
    chk("abort_flags", longint'({ng[1], of[1], bl12}), 0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[1]) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    conv(1, 999, 0, 0, r_bcd, r_neg, r_ovf, r_blank, lat);
    chk("post_abort_bcd", r_bcd, 'h999);
    chk("post_abort_ovf", longint'(r_ovf), 0);
    for (int i = 0; i < 60; i++) begin
      int     s;
      longint v;
      bit     sgn;
      s = i % 2;
      v = s != 0 ? longint'($urandom_range(4095)) : longint'($urandom_range(65535));
      if (i % 10 == 3) v = 0;
      sgn = 1'($urandom);
      model(s != 0 ? 12 : 16, s != 0 ? 3 : 5, v, sgn, m_bcd, m_neg, m_ovf, m_blank);
      conv(s, v, sgn, i % 7 == 0 ? 2 : 0, r_bcd, r_neg, r_ovf, r_blank, lat);
      chk($sformatf("rnd%0d_bcd v=%0h s=%0d", i, v, sgn), r_bcd, m_bcd);
      chk($sformatf("rnd%0d_neg", i), longint'(r_neg), longint'(m_neg));
      chk($sformatf("rnd%0d_ovf", i), longint'(r_ovf), longint'(m_ovf));
      chk($sformatf("rnd%0d_blank", i), r_blank, m_blank);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
